// File: rtl/rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// rom_fetch_arbiter
//
// Shares the single-port instruction ROM between the CPU instruction-fetch
// port (IF) and a debug/loader read port (DBG). This block sits between the
// core and the ROM. It is fully pipelined:
//   - The address phase is in cycle N. The grant, rom_ce_o and rom_addr_o are
//     all combinational.
//   - The data phase is in cycle N+1. rvalid is registered and rdata passes
//     through from the ROM.
//
// IF has priority. A burst counter limits IF to BURST_MAX consecutive grants
// while DBG is waiting. DBG then takes the next cycle, which guarantees that
// DBG makes forward progress.
//
// Parameters:
//   ADDR_W    - address bus width
//   DATA_W    - data bus width
//   BURST_MAX - max consecutive IF grants while DBG waits (1..255)
//   CNT_W     - burst counter width, 2**CNT_W > BURST_MAX
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   if_req_i / if_addr_i         - IF request and byte address
//   if_gnt_o                     - IF accepted this cycle (combinational)
//   if_stall_o                   - IF requesting but not granted
//   if_rvalid_o / if_rdata_o     - IF response, one cycle after grant
//   dbg_req_i / dbg_addr_i       - DBG request and byte address
//   dbg_gnt_o                    - DBG accepted this cycle (combinational)
//   dbg_rvalid_o / dbg_rdata_o   - DBG response, one cycle after grant
//   rom_ce_o / rom_addr_o        - ROM chip enable and address
//   rom_data_i                   - ROM data, valid the cycle after rom_ce_o
// -----------------------------------------------------------------------------
module rom_fetch_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_stall_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,

  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,

  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             resp_if_q, resp_if_d;
  logic             resp_dbg_q, resp_dbg_d;
  logic             if_win, dbg_win;
  logic             dbg_turn;

  // DBG wins a contended cycle only once IF has used up its burst allowance.
  assign dbg_turn = dbg_req_i && (burst_cnt_q >= BURST_LIM);

  // Grant decision.
  // While rst is high, nothing is granted, so every combinational output
  // is forced to its idle value.
  always_comb begin
    if_win  = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      if (if_req_i && !dbg_turn) begin
        if_win = 1'b1;
      end else if (dbg_req_i) begin
        dbg_win = 1'b1;
      end
    end
  end

  // Next state for the burst counter and the response tracking.
  //
  // The counter only advances while DBG is actually waiting. Any DBG grant
  // or withdrawal clears it.
  //
  // An IF grant with dbg_req_i high implies burst_cnt_q < BURST_LIM, so the
  // increment can never run past BURST_MAX.
  always_comb begin
    burst_cnt_d = '0;
    if (if_win && dbg_req_i) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
    resp_if_d  = if_win;
    resp_dbg_d = dbg_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
      resp_if_q   <= 1'b0;
      resp_dbg_q  <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      resp_if_q   <= resp_if_d;
      resp_dbg_q  <= resp_dbg_d;
    end
  end

  // Address phase.
  assign if_gnt_o   = if_win;
  assign dbg_gnt_o  = dbg_win;
  assign if_stall_o = if_req_i & ~if_win & ~rst;
  assign rom_ce_o   = if_win | dbg_win;

  always_comb begin
    rom_addr_o = '0;
    if (if_win) begin
      rom_addr_o = if_addr_i;
    end else if (dbg_win) begin
      rom_addr_o = dbg_addr_i;
    end
  end

  // Data phase.
  // The rvalid outputs are masked by rst. A response that is in flight
  // when reset hits therefore never reaches the requester, even though the
  // tracking flop still holds it for that one cycle.
  assign if_rvalid_o  = resp_if_q & ~rst;
  assign dbg_rvalid_o = resp_dbg_q & ~rst;
  assign if_rdata_o   = if_rvalid_o  ? rom_data_i : '0;
  assign dbg_rdata_o  = dbg_rvalid_o ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for rom_fetch_arbiter, with BURST_MAX = 4.
//
// A small ROM model returns {16'hC0DE, word_index[15:0]} one cycle after
// rom_ce_o. When rom_ce_o is low, the model holds its last data. It
// powers up as 32'hDEADBEEF, so a missing ZeroWord mask shows up as a
// mismatch.
//
// Inputs are driven at the falling edge. All outputs are sampled 1 time
// unit later, inside the same cycle.
// -----------------------------------------------------------------------------
module tb_rom_fetch_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_stall_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dbg_req_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic              dbg_gnt_o;
  logic              dbg_rvalid_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_fetch_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BURST_MAX(4),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_stall_o  (if_stall_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dbg_req_i   (dbg_req_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_gnt_o   (dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o),
    .dbg_rdata_o (dbg_rdata_o),
    .rom_ce_o    (rom_ce_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i)
  );

  // ROM model: word-addressed, registered read.
  initial rom_data_i = 32'hDEADBEEF;
  always @(posedge clk) begin
    if (rom_ce_o) begin
      rom_data_i <= {16'hC0DE, rom_addr_o[17:2]};
    end
  end

  // Observation vector:
  //   flags = {if_gnt, dbg_gnt, rom_ce, if_stall, if_rvalid, dbg_rvalid}
  //   then rom_addr, if_rdata, dbg_rdata
  logic [101:0] obs;
  assign obs = {if_gnt_o, dbg_gnt_o, rom_ce_o, if_stall_o, if_rvalid_o,
                dbg_rvalid_o, rom_addr_o, if_rdata_o, dbg_rdata_o};

  typedef struct packed {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic [31:0] da;
    logic [5:0]  flg;
    logic [31:0] addr;
    logic [31:0] ifd;
    logic [31:0] dbgd;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic ifr,
                               input logic [31:0] ifa, input logic dr,
                               input logic [31:0] da, input logic [5:0] flg,
                               input logic [31:0] addr, input logic [31:0] ifd,
                               input logic [31:0] dbgd);
    vec_t v;
    v.rst = r;    v.ifr = ifr;   v.ifa = ifa;  v.dr = dr; v.da = da;
    v.flg = flg;  v.addr = addr; v.ifd = ifd;  v.dbgd = dbgd;
    return v;
  endfunction

  // Drive one cycle's inputs, then print the transaction line.
  task automatic apply(input string name, input int idx, input vec_t v);
    @(negedge clk);
    rst        = v.rst;
    if_req_i   = v.ifr;
    if_addr_i  = v.ifa;
    dbg_req_i  = v.dr;
    dbg_addr_i = v.da;
    #1;
    $display("%s[%0d] rst=%0b ifr=%0b dr=%0b flags=%b addr=%h ifd=%h dbgd=%h",
             name, idx, v.rst, v.ifr, v.dr, obs[101:96], obs[95:64],
             obs[63:32], obs[31:0]);
  endtask

  task automatic test_reset();
    vec_t v[$];
    logic [101:0] exp;
    v.push_back(mkv(1, 1, 32'h20, 1, 32'h100, 6'b000000, 32'h0, 32'h0, 32'h0));
    v.push_back(mkv(1, 1, 32'h20, 1, 32'h100, 6'b000000, 32'h0, 32'h0, 32'h0));
    v.push_back(mkv(1, 1, 32'h20, 1, 32'h100, 6'b000000, 32'h0, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'h20, 1, 32'h100, 6'b101000, 32'h20, 32'h0, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'hC0DE0008, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0));
    foreach (v[i]) begin
      apply("reset", i, v[i]);
      exp = {v[i].flg, v[i].addr, v[i].ifd, v[i].dbgd};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got flags=%b addr=%h ifd=%h dbgd=%h; expected flags=%b addr=%h ifd=%h dbgd=%h",
                 i, obs[101:96], obs[95:64], obs[63:32], obs[31:0],
                 exp[101:96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_if_stream();
    vec_t v[$];
    logic [101:0] exp;
    v.push_back(mkv(0, 1, 32'h0, 0, 32'h0, 6'b101000, 32'h0, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'h4, 0, 32'h0, 6'b101010, 32'h4, 32'hC0DE0000, 32'h0));
    v.push_back(mkv(0, 1, 32'h8, 0, 32'h0, 6'b101010, 32'h8, 32'hC0DE0001, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'hC0DE0002, 32'h0));
    foreach (v[i]) begin
      apply("if_stream", i, v[i]);
      exp = {v[i].flg, v[i].addr, v[i].ifd, v[i].dbgd};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL if_stream[%0d]: got flags=%b addr=%h ifd=%h dbgd=%h; expected flags=%b addr=%h ifd=%h dbgd=%h",
                 i, obs[101:96], obs[95:64], obs[63:32], obs[31:0],
                 exp[101:96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  // With BURST_MAX=4, the expected grant pattern is IF,IF,IF,IF,DBG repeating.
  task automatic test_contention();
    vec_t v[$];
    logic [101:0] exp;
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101000, 32'h40, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b011110, 32'h100, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101001, 32'h40, 32'h0, 32'hC0DE0040));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b011110, 32'h100, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101001, 32'h40, 32'h0, 32'hC0DE0040));
    v.push_back(mkv(0, 1, 32'h40, 1, 32'h100, 6'b101010, 32'h40, 32'hC0DE0010, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000010, 32'h0, 32'hC0DE0010, 32'h0));
    foreach (v[i]) begin
      apply("contention", i, v[i]);
      exp = {v[i].flg, v[i].addr, v[i].ifd, v[i].dbgd};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL contention[%0d]: got flags=%b addr=%h ifd=%h dbgd=%h; expected flags=%b addr=%h ifd=%h dbgd=%h",
                 i, obs[101:96], obs[95:64], obs[63:32], obs[31:0],
                 exp[101:96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_dbg_only();
    vec_t v[$];
    logic [101:0] exp;
    v.push_back(mkv(0, 0, 32'h0, 1, 32'h100, 6'b011000, 32'h100, 32'h0, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'hC0DE0040));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0));
    foreach (v[i]) begin
      apply("dbg_only", i, v[i]);
      exp = {v[i].flg, v[i].addr, v[i].ifd, v[i].dbgd};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL dbg_only[%0d]: got flags=%b addr=%h ifd=%h dbgd=%h; expected flags=%b addr=%h ifd=%h dbgd=%h",
                 i, obs[101:96], obs[95:64], obs[63:32], obs[31:0],
                 exp[101:96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  // The burst counter is raised to 3 before reset. After reset, a full
  // set of 4 IF grants must precede the next DBG grant.
  task automatic test_reset_midflight();
    vec_t v[$];
    logic [101:0] exp;
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101000, 32'hC, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101010, 32'hC, 32'hC0DE0003, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101010, 32'hC, 32'hC0DE0003, 32'h0));
    v.push_back(mkv(1, 1, 32'hC, 1, 32'h100, 6'b000000, 32'h0, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101000, 32'hC, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101010, 32'hC, 32'hC0DE0003, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101010, 32'hC, 32'hC0DE0003, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b101010, 32'hC, 32'hC0DE0003, 32'h0));
    v.push_back(mkv(0, 1, 32'hC, 1, 32'h100, 6'b011110, 32'h100, 32'hC0DE0003, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'hC0DE0040));
    foreach (v[i]) begin
      apply("reset_midflight", i, v[i]);
      exp = {v[i].flg, v[i].addr, v[i].ifd, v[i].dbgd};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_midflight[%0d]: got flags=%b addr=%h ifd=%h dbgd=%h; expected flags=%b addr=%h ifd=%h dbgd=%h",
                 i, obs[101:96], obs[95:64], obs[63:32], obs[31:0],
                 exp[101:96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  // DBG waits 2 cycles and then withdraws. The counter must clear, so the
  // next contention again gives 4 IF grants before DBG.
  task automatic test_withdrawal();
    vec_t v[$];
    logic [101:0] exp;
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b101000, 32'h10, 32'h0, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b101010, 32'h10, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 0, 32'h0, 6'b101010, 32'h10, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b101010, 32'h10, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b101010, 32'h10, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b101010, 32'h10, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b101010, 32'h10, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 1, 32'h10, 1, 32'h100, 6'b011110, 32'h100, 32'hC0DE0004, 32'h0));
    v.push_back(mkv(0, 0, 32'h0, 0, 32'h0, 6'b000001, 32'h0, 32'h0, 32'hC0DE0040));
    foreach (v[i]) begin
      apply("withdrawal", i, v[i]);
      exp = {v[i].flg, v[i].addr, v[i].ifd, v[i].dbgd};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL withdrawal[%0d]: got flags=%b addr=%h ifd=%h dbgd=%h; expected flags=%b addr=%h ifd=%h dbgd=%h",
                 i, obs[101:96], obs[95:64], obs[63:32], obs[31:0],
                 exp[101:96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    dbg_req_i  = 1'b0;
    dbg_addr_i = '0;
    test_reset();
    test_if_stream();
    test_contention();
    test_dbg_only();
    test_reset_midflight();
    test_withdrawal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
